// File: rtl/regfile_pkg.sv
// Shared widths, constants and the writeback request record used around the
// register file write port.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  // x0 is hardwired to zero: writes to it are dropped, reads of it never bypass.
  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the first asserted request at or after ptr (wrapping)
// wins. en=0 suppresses every grant.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      gnt_idx_o,
  output logic               any_o
);

  // Scan from the pointer position and keep only the first valid requester.
  always_comb begin
    int  c;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    found     = 1'b0;
    c         = 0;
    if (en_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (int'(ptr_i) + k) % NUM_REQ;
        if (!found && req_i[c]) begin
          found     = 1'b1;
          gnt_o[c]  = 1'b1;
          gnt_idx_o = PW'(c);
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between several writeback
// sources. The winner is registered into a one-entry write stage, and the two
// read ports are bypassed from that stage so readers see the in-flight write.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int AW      = regfile_pkg::AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*AW-1:0]     req_addr,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      RegWrite,
  output logic [AW-1:0]             addD,
  output logic [XLEN-1:0]           WB_out,
  input  logic [AW-1:0]             addA,
  input  logic [AW-1:0]             addB,
  input  logic [XLEN-1:0]           rf_dataA,
  input  logic [XLEN-1:0]           rf_dataB,
  output logic [XLEN-1:0]           dataA,
  output logic [XLEN-1:0]           dataB
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   addd_q, addd_d;
  logic [XLEN-1:0] wb_q, wb_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               arb_en;

  // Grants are suppressed while frozen and during a reset cycle.
  assign arb_en = !hold && rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign req_ready = gnt;

  // Next-state: load the winner into the write stage and move the pointer
  // past it; an x0 winner still consumes its turn but never asserts RegWrite.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    regwrite_d = 1'b0;
    addd_d     = addd_q;
    wb_d       = wb_q;
    if (gnt_any) begin
      rr_ptr_d   = PW'((int'(gnt_idx) + 1) % NUM_REQ);
      addd_d     = req_addr[int'(gnt_idx)*AW +: AW];
      wb_d       = req_data[int'(gnt_idx)*XLEN +: XLEN];
      regwrite_d = (addd_d != X0);
    end
  end

  // Write stage and pointer registers; reset discards any in-flight write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      regwrite_q <= 1'b0;
      addd_q     <= '0;
      wb_q       <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      regwrite_q <= regwrite_d;
      addd_q     <= addd_d;
      wb_q       <= wb_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign addD     = addd_q;
  assign WB_out   = wb_q;

  // Read bypass from the registered write stage; x0 reads always come from the file.
  always_comb begin
    dataA = rf_dataA;
    dataB = rf_dataB;
    if (regwrite_q && (addd_q == addA) && (addA != X0)) dataA = wb_q;
    if (regwrite_q && (addd_q == addB) && (addB != X0)) dataB = wb_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter: reset, round-robin order, x0 drop,
// read bypass, hold and mid-operation reset.
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int XL = 32;

  logic               clk;
  logic               rst_n;
  logic               hold;
  logic [NR-1:0]      req_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*XL-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               RegWrite;
  logic [AW-1:0]      addD;
  logic [XL-1:0]      WB_out;
  logic [AW-1:0]      addA, addB;
  logic [XL-1:0]      rf_dataA, rf_dataB;
  logic [XL-1:0]      dataA, dataB;

  int n_tests;
  int n_fail;

  regfile_wb_arbiter #(
    .NUM_REQ (NR),
    .XLEN    (XL),
    .AW      (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RegWrite  (RegWrite),
    .addD      (addD),
    .WB_out    (WB_out),
    .addA      (addA),
    .addB      (addB),
    .rf_dataA  (rf_dataA),
    .rf_dataB  (rf_dataB),
    .dataA     (dataA),
    .dataB     (dataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XL-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*XL +: XL] = d;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    addA      = '0;
    addB      = '0;
    rf_dataA  = '0;
    rf_dataB  = '0;
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);

    // Reset: no grants, cleared write stage
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'h0);
    tick();
    check_eq("rst_ready_c1", 64'(req_ready), 64'h0);
    tick();
    check_eq("rst_regwrite", 64'(RegWrite), 64'h0);
    check_eq("rst_addD", 64'(addD), 64'h0);
    check_eq("rst_wb", 64'(WB_out), 64'h0);

    // Round robin 0,1,2,0 with one-cycle write latency
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      check_eq($sformatf("rr_regwrite_%0d", k), 64'(RegWrite), 64'h1);
      check_eq($sformatf("rr_addD_%0d", k), 64'(addD), 64'((k % 3) + 1));
      check_eq($sformatf("rr_wb_%0d", k), 64'(WB_out), 64'(32'hA + (k % 3)));
    end

    // x0 request from requester 1 (pointer is 1): handshake, no write
    set_req(1, 5'd0, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    check_eq("x0_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    #1;
    check_eq("x0_idle_ready", 64'(req_ready), 64'h0);
    check_eq("x0_regwrite", 64'(RegWrite), 64'h0);
    // pointer advanced to 2
    set_req(1, 5'd2, 32'hB);
    req_valid = 3'b111;
    #1;
    check_eq("x0_ptr_ready", 64'(req_ready), 64'b100);
    tick();
    check_eq("x0_ptr_addD", 64'(addD), 64'd3);
    check_eq("x0_ptr_regwrite", 64'(RegWrite), 64'h1);

    // Bypass: x5 = 0x12345678 from requester 0 (pointer is 0)
    set_req(0, 5'd5, 32'h12345678);
    req_valid = 3'b001;
    #1;
    check_eq("byp_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    addA = 5'd5;  rf_dataA = 32'h0;
    addB = 5'd6;  rf_dataB = 32'h55AA55AA;
    #1;
    check_eq("byp_dataA", 64'(dataA), 64'h12345678);
    check_eq("byp_dataB", 64'(dataB), 64'h55AA55AA);
    tick();
    rf_dataA = 32'h00000077;
    #1;
    check_eq("byp_idle_regwrite", 64'(RegWrite), 64'h0);
    check_eq("byp_idle_addD_hold", 64'(addD), 64'd5);
    check_eq("byp_idle_wb_hold", 64'(WB_out), 64'h12345678);
    check_eq("byp_idle_dataA", 64'(dataA), 64'h77);

    // x0 must not bypass (pointer is 1; requester 0 alone still wins)
    set_req(0, 5'd0, 32'h0BADF00D);
    req_valid = 3'b001;
    #1;
    check_eq("bx0_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    addA = 5'd0;  rf_dataA = 32'h11111111;
    addB = 5'd0;  rf_dataB = 32'h22222222;
    #1;
    check_eq("bx0_dataA", 64'(dataA), 64'h11111111);
    check_eq("bx0_dataB", 64'(dataB), 64'h22222222);

    // Hold: pointer is 1, requesters 0 and 1 valid
    set_req(0, 5'd7, 32'h70);
    set_req(1, 5'd8, 32'h80);
    req_valid = 3'b011;
    #1;
    check_eq("hold_pre_ready", 64'(req_ready), 64'b010);
    tick();
    hold = 1'b1;
    #1;
    check_eq("hold_c1_ready", 64'(req_ready), 64'h0);
    check_eq("hold_c1_regwrite", 64'(RegWrite), 64'h1);
    check_eq("hold_c1_addD", 64'(addD), 64'd8);
    tick();
    check_eq("hold_c2_ready", 64'(req_ready), 64'h0);
    check_eq("hold_c2_regwrite", 64'(RegWrite), 64'h0);
    tick();
    check_eq("hold_c3_ready", 64'(req_ready), 64'h0);
    check_eq("hold_c3_regwrite", 64'(RegWrite), 64'h0);
    tick();
    hold = 1'b0;
    #1;
    check_eq("hold_rel_ready", 64'(req_ready), 64'b001);
    tick();
    check_eq("hold_rel_addD", 64'(addD), 64'd7);
    check_eq("hold_rel_wb", 64'(WB_out), 64'h70);

    // Mid-operation reset after a grant to requester 2 (pointer is 1)
    set_req(2, 5'd9, 32'h99);
    req_valid = 3'b100;
    #1;
    check_eq("mrst_ready", 64'(req_ready), 64'b100);
    tick();
    rst_n = 1'b0;
    req_valid = 3'b111;
    #1;
    check_eq("mrst_ready_in_rst", 64'(req_ready), 64'h0);
    tick();
    check_eq("mrst_regwrite", 64'(RegWrite), 64'h0);
    check_eq("mrst_addD", 64'(addD), 64'h0);
    check_eq("mrst_wb", 64'(WB_out), 64'h0);
    rst_n = 1'b1;
    #1;
    check_eq("mrst_ptr_ready", 64'(req_ready), 64'b001);
    tick();
    check_eq("mrst_after_addD", 64'(addD), 64'd7);
    check_eq("mrst_after_regwrite", 64'(RegWrite), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters (ALU, load unit, multicycle mul/div), with round-robin arbitration and a valid/ready handshake.
- The winner is registered into a one-entry write stage that drives the register file's RegWrite/addD/WB_out for exactly one cycle.
- Provides read-port bypass so same-cycle readers see the in-flight write.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters; legal range 2..8.
- XLEN, 32, data width.
- AW, 5, register address width (32 architectural registers, x0 hardwired zero).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- hold  input  1  freezes arbitration; no grants while high.
- req_valid  input  NUM_REQ  requester i has a pending write.
- req_addr  input  NUM_REQ*AW  destination register per requester; requester i occupies bits [i*AW +: AW].
- req_data  input  NUM_REQ*XLEN  write data per requester; requester i occupies bits [i*XLEN +: XLEN].
- req_ready  output  NUM_REQ  one-hot or zero grant; the handshake completes when valid&&ready.
- RegWrite  output  1  register file write enable.
- addD  output  AW  register file write address.
- WB_out  output  XLEN  register file write data.
- addA, addB  input  AW  register file read addresses (same as sent to the register file).
- rf_dataA, rf_dataB  input  XLEN  raw register file read data.
- dataA, dataB  output  XLEN  bypassed read data for the datapath.

Behaviour:
- Reset (rst_n=0 at a rising edge): RegWrite=0, addD=0, WB_out=0, rr_ptr=0. No grants are issued in a reset cycle (req_ready=0 while rst_n=0).
- Arbitration is combinational from the current state:
  - When hold=0, the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo NUM_REQ, gets req_ready[i]=1.
  - All other req_ready bits are 0.
  - When hold=1 or no requester is valid, req_ready=0.
- Pointer update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Write stage:
  - On a grant to i, the next cycle has RegWrite=1, addD=req_addr[i], WB_out=req_data[i].
  - With no grant, RegWrite=0 next cycle; addD and WB_out hold their last values.
  - Latency is exactly 1 cycle from handshake to the register file write edge.
  - The stage never stalls; one write retires per cycle.
- x0 requests: a handshake with req_addr=0 completes normally and consumes the grant and the pointer advance. The write stage then presents RegWrite=0 (the write is dropped).
- Requester contract: req_addr and req_data must stay stable while valid is high and ready is low. A requester may deassert valid only after its handshake completes. The block does not check this contract.
- Bypass:
  - dataA = WB_out if (RegWrite && addD==addA && addA!=0); otherwise rf_dataA.
  - dataB uses the same rule with addB and rf_dataB.
  - Purely combinational, registered write-stage vs read address; requesters in the current cycle are not bypassed.
- Simultaneous events:
  - hold rising while RegWrite=1: the in-flight write still retires. Grants stop in the same cycle hold is sampled high.
  - Reset mid-operation: the in-flight write is discarded (RegWrite=0 next cycle) and pending requests are not granted. rr_ptr returns to 0.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles while hold=0.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN, AW and NREGS=32;
  - a ZERO_REG constant of 0;
  - a wb_req_t struct {logic [AW-1:0] addr; logic [XLEN-1:0] data;}.
- One natural sub-module: rr_arbiter. It is a parameterized NUM_REQ round-robin picker (inputs: req, ptr, en; outputs: onehot grant, grant index, any).
- The bypass muxes and the write stage stay in regfile_wb_arbiter.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, RegWrite=0, addD=0, WB_out=0. After release, the first grant goes to requester 0.
- Round-robin: hold req_valid=3'b111 with addr 1/2/3 and data 0xA/0xB/0xC -> grants are 0,1,2,0,… on consecutive cycles. RegWrite=1 every cycle; addD sequence 1,2,3,1 one cycle after each grant.
- x0 drop: requester 1 alone sends addr=0, data=0xDEADBEEF -> req_ready[1]=1 for 1 cycle. Next cycle RegWrite=0 and rr_ptr=2.
- Bypass: requester 0 writes x5=0x12345678; in the retire cycle addA=5, rf_dataA=0 -> dataA=0x12345678. With addB=6 -> dataB=rf_dataB. Repeat with x0 -> no bypass.
- Hold: with req_valid=3'b011, assert hold for 3 cycles -> req_ready=0 and RegWrite=0 after the in-flight write retires. On release, the grant resumes at the saved rr_ptr.
- Mid-operation reset: a grant to requester 2 at cycle N, then rst_n=0 at cycle N+1 -> RegWrite=0 at N+2, with no write to the register file.
